// File: rtl/sort_frame_ctrl.sv
// Frame sequencer around a parallel byte sorter: gathers NUM_ELEM elements, waits out the
// sorter latency, then streams the sorted frame back out ascending or descending.
module sort_frame_ctrl #(
  parameter int NUM_ELEM = 8,
  parameter int DW       = 8,
  parameter int SORT_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW-1:0]          in_data,
  input  logic                   in_desc,
  output logic [NUM_ELEM*DW-1:0] srt_data_o,
  input  logic [NUM_ELEM*DW-1:0] srt_data_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DW-1:0]          out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic [15:0]            frame_cnt,
  output logic [1:0]             dbg_state
);

  localparam int CW = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
  localparam int WW = $clog2(SORT_LAT + 1) > 0 ? $clog2(SORT_LAT + 1) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_ELEM - 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SORT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                   state, state_nx;
  logic [CW-1:0]            cnt;
  logic [CW-1:0]            idx;
  logic [CW-1:0]            sel;
  logic [WW-1:0]            wait_cnt;
  logic                     desc;
  logic [NUM_ELEM*DW-1:0]   res;
  logic                     in_acc;
  logic                     out_acc;
  logic                     wait_done;

  // Both streams use valid/ready: a transfer happens on any rising edge where valid and
  // ready are both high; once out_valid is raised, out_data/out_last hold until that edge.
  assign in_acc    = in_valid & in_ready;
  assign out_acc   = out_valid & out_ready;
  assign wait_done = (wait_cnt == WW'(SORT_LAT));
  assign dbg_state = state;

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && cnt == LAST_IDX) state_nx = S_SORT;
      end
      S_SORT: begin
        busy = 1'b1;
        if (wait_done) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready && idx == LAST_IDX) state_nx = S_LOAD;
      end
      default: state_nx = S_LOAD;
    endcase
  end

  // Descending order is just the ascending result read from the top lane down.
  assign sel      = desc ? (LAST_IDX - idx) : idx;
  assign out_data = res[sel*DW +: DW];
  assign out_last = out_valid && (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_LOAD;
      cnt        <= '0;
      idx        <= '0;
      wait_cnt   <= '0;
      desc       <= 1'b0;
      srt_data_o <= '0;
      res        <= '0;
      frame_cnt  <= '0;
    end else begin
      state <= state_nx;
      if (in_acc) begin
        srt_data_o[cnt*DW +: DW] <= in_data;
        if (cnt == '0) desc <= in_desc;
        cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
      end
      // Counter is cleared outside SORT, so it starts at zero on the edge after the last accept.
      if (state == S_SORT) wait_cnt <= wait_cnt + 1'b1;
      else                 wait_cnt <= '0;
      if (state == S_SORT && wait_done) begin
        res <= srt_data_i;
        idx <= '0;
      end
      if (out_acc) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        if (idx == LAST_IDX) frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/sort_frame_ctrl.md
Name: sort_frame_ctrl

Overview:
- Sequencer for the 8-lane, 8-bit parallel sorter (two-cycle registered latency).
- Collects a frame of NUM_ELEM bytes from a valid/ready input stream and drives them to the sorter as one parallel word.
- Waits out the sorter pipeline latency, captures the sorted word, and streams it back out byte by byte, ascending or descending, with backpressure and a last-marker.

Parameters:
- NUM_ELEM, 8: bytes per frame; must match the sorter lane count.
- DW, 8: element width in bits.
- SORT_LAT, 2: sorter latency in clocks, from a stable input word to a valid result word.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  controller can accept an element.
- in_data  in  DW  input element.
- in_desc  in  1  order select, sampled with the first element of a frame: 0 = ascending, 1 = descending.
- srt_data_o  out  NUM_ELEM*DW  to sorter; element k (0-based arrival order) on bits [DW*k+DW-1 : DW*k].
- srt_data_i  in  NUM_ELEM*DW  from sorter; same packing, ascending from lane 0.
- out_valid  out  1  output element valid.
- out_ready  in  1  downstream accepts an element.
- out_data  out  DW  output element.
- out_last  out  1  high with the final element of a frame.
- busy  out  1  high in SORT or DRAIN.
- frame_cnt  out  16  frames fully drained; wraps 0xFFFF -> 0.

Behaviour:
- Reset (rst_n=0 at an edge):
  - State = LOAD, element count = 0.
  - out_valid=0, out_last=0, out_data=0, srt_data_o=0, frame_cnt=0, busy=0.
  - in_ready=1 from the first cycle after reset releases.
  - Reset mid-frame discards all partial data. Nothing further is emitted for that frame.
- Handshake:
  - Transfer occurs on an edge where valid&ready=1.
  - out_data and out_last are held stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a transfer.
- LOAD:
  - in_ready=1.
  - Each accept writes in_data into element register [cnt] and increments cnt.
  - The accept at cnt=0 also latches in_desc.
  - The accept at cnt=NUM_ELEM-1 goes to SORT with the wait counter cleared.
  - srt_data_o is the element register bank, registered; it is stable throughout SORT.
- SORT:
  - in_ready=0, busy=1.
  - The wait counter increments each cycle.
  - If the 8th accept is at edge T, srt_data_i is captured into the result buffer at edge T+SORT_LAT+1, and the state moves to DRAIN at that same edge.
  - srt_data_i is ignored at all other times.
- DRAIN:
  - out_valid=1 from the cycle after the capture edge, so the first output is valid SORT_LAT+1 cycles after the last input accept.
  - Output index i runs 0..NUM_ELEM-1.
  - out_data = result lane i if ascending, lane NUM_ELEM-1-i if descending.
  - out_last=1 only at i=NUM_ELEM-1.
  - Each accept advances i.
  - The accept with out_last=1: frame_cnt+1, return to LOAD, clear cnt, out_valid=0 next cycle.
- No frame overlap:
  - in_ready=0 throughout SORT and DRAIN; input arriving then is backpressured, not dropped.
  - Minimum frame period = NUM_ELEM + SORT_LAT + 1 + NUM_ELEM cycles.
- Duplicates and values 0x00/0xFF need no special handling. Ordering among equal values is irrelevant, since equal bytes are indistinguishable.
- in_valid held low in LOAD: the controller waits indefinitely, keeping partial elements.

Test Plan:
- Reset, then feed 0x50,0x10,0x80,0x20,0xFF,0x00,0x30,0x70 back-to-back, ascending, out_ready=1 → out_data 0x00,0x10,0x20,0x30,0x50,0x70,0x80,0xFF in consecutive cycles. First out_valid 3 cycles after the 8th accept. out_last on 0xFF. frame_cnt=1.
- Same data with in_desc=1 on the first element → 0xFF,0x80,0x70,0x50,0x30,0x20,0x10,0x00; out_last on 0x00.
- Toggle out_ready 1,0,0,1,… during DRAIN → out_data stable while stalled, no element lost or repeated. in_ready stays 0 until the out_last transfer completes, then returns to 1.
- Input 0x05 ×4 then 0x01 ×4, with in_valid gaps of 2 cycles between bytes → output 0x01×4, 0x05×4. srt_data_o constant through SORT.
- Assert rst_n=0 for one cycle after the 5th accept, then send a clean frame 8,7,6,5,4,3,2,1 → output 1..8 only; no residue of the aborted frame; frame_cnt=1.
- Preload frame_cnt to 0xFFFF (force), complete one frame → frame_cnt=0x0000.
